// File: rtl/amds_axi_regbank.sv
// AXI4-Lite slave register bank for the AMDS sensor interface: RW control registers,
// per-channel read-only sample registers with new-data/overrun tracking, and a masked interrupt.
module amds_axi_regbank #(
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_ADDR_WIDTH   = 8,
    parameter int N_CTRL         = 4,
    parameter int N_CH           = 8,
    parameter int C_SAMPLE_WIDTH = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    output logic [N_CTRL*C_DATA_WIDTH-1:0]   ctrl_out,
    input  logic [N_CH*C_SAMPLE_WIDTH-1:0]   smp_data,
    input  logic [N_CH-1:0]                  smp_valid,
    output logic                             irq
);

    localparam int          STRB_W      = C_DATA_WIDTH / 8;
    localparam int          ADDR_LSB    = $clog2(STRB_W);
    localparam logic [31:0] IDX_NEW     = 32'(N_CTRL);
    localparam logic [31:0] IDX_OVR     = 32'(N_CTRL + 1);
    localparam logic [31:0] IDX_SMP     = 32'(N_CTRL + 2);
    localparam logic [31:0] IDX_END     = 32'(N_CTRL + 2 + N_CH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    function automatic logic [C_DATA_WIDTH-1:0] apply_strb(
        input logic [C_DATA_WIDTH-1:0] old_val,
        input logic [C_DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]       strb
    );
        logic [C_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    logic [C_DATA_WIDTH-1:0]   ctrl_r [N_CTRL];
    logic [C_SAMPLE_WIDTH-1:0] sample_r [N_CH];
    logic [N_CH-1:0]           new_r;
    logic [N_CH-1:0]           ovr_r;
    logic                      irq_r;
    logic                      aw_ready_r;
    logic                      bvalid_r;
    logic [1:0]                bresp_r;
    logic                      ar_ready_r;
    logic                      rvalid_r;
    logic [1:0]                rresp_r;
    logic [C_DATA_WIDTH-1:0]   rdata_r;

    logic [31:0]               wr_idx_s;
    logic [31:0]               rd_idx_s;
    logic                      wr_hs_s;
    logic                      rd_hs_s;
    logic [1:0]                wr_resp_s;
    logic [1:0]                rd_resp_s;
    logic [C_DATA_WIDTH-1:0]   rd_data_s;
    logic [C_DATA_WIDTH-1:0]   ctrl_sel_s;
    logic [C_SAMPLE_WIDTH-1:0] smp_sel_s;
    logic [N_CH-1:0]           new_clr_s;
    logic [N_CH-1:0]           ovr_clr_s;
    logic                      unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign wr_idx_s = 32'(S_AXI_AWADDR >> ADDR_LSB);
    assign rd_idx_s = 32'(S_AXI_ARADDR >> ADDR_LSB);
    assign wr_hs_s  = aw_ready_r & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs_s  = ar_ready_r & S_AXI_ARVALID;

    // Write decode: response code and per-lane OVR clear mask.
    always_comb begin
        ovr_clr_s = '0;
        wr_resp_s = (wr_idx_s < IDX_END) ? RESP_OKAY : RESP_SLVERR;
        for (int c = 0; c < N_CH; c++) begin
            ovr_clr_s[c] = wr_hs_s & (wr_idx_s == IDX_OVR) & S_AXI_WDATA[c] & S_AXI_WSTRB[c/8];
        end
    end

    // Read decode: data mux, response code and NEW clear on a SAMPLE read handshake.
    always_comb begin
        ctrl_sel_s = '0;
        smp_sel_s  = '0;
        new_clr_s  = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            ctrl_sel_s = ctrl_sel_s | ((rd_idx_s == 32'(k)) ? ctrl_r[k] : '0);
        end
        for (int c = 0; c < N_CH; c++) begin
            smp_sel_s    = smp_sel_s | ((rd_idx_s == IDX_SMP + 32'(c)) ? sample_r[c] : '0);
            new_clr_s[c] = rd_hs_s & (rd_idx_s == IDX_SMP + 32'(c));
        end
        if (rd_idx_s < IDX_NEW) begin
            rd_data_s = ctrl_sel_s;
            rd_resp_s = RESP_OKAY;
        end else if (rd_idx_s == IDX_NEW) begin
            rd_data_s = C_DATA_WIDTH'(new_r);
            rd_resp_s = RESP_OKAY;
        end else if (rd_idx_s == IDX_OVR) begin
            rd_data_s = C_DATA_WIDTH'(ovr_r);
            rd_resp_s = RESP_OKAY;
        end else if (rd_idx_s < IDX_END) begin
            rd_data_s = C_DATA_WIDTH'(smp_sel_s);
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Control registers, byte-strobed on the write handshake edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < N_CTRL; k++) ctrl_r[k] <= '0;
        end else begin
            for (int k = 0; k < N_CTRL; k++) begin
                if (wr_hs_s && (wr_idx_s == 32'(k))) begin
                    ctrl_r[k] <= apply_strb(ctrl_r[k], S_AXI_WDATA, S_AXI_WSTRB);
                end
            end
        end
    end

    // Sample capture with NEW/OVR tracking; a fresh sample always beats a clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int c = 0; c < N_CH; c++) sample_r[c] <= '0;
            new_r <= '0;
            ovr_r <= '0;
            irq_r <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (smp_valid[c]) sample_r[c] <= smp_data[c*C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH];
            end
            new_r <= (new_r & ~new_clr_s) | smp_valid;
            ovr_r <= (ovr_r & ~ovr_clr_s) | (smp_valid & new_r);
            irq_r <= |(new_r & ctrl_r[0][N_CH-1:0]);
        end
    end

    // Write channel handshake and response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready_r <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
        end else begin
            aw_ready_r <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_r & ~aw_ready_r;
            if (wr_hs_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_resp_s;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read channel handshake and registered data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_ready_r <= 1'b0;
            rvalid_r   <= 1'b0;
            rresp_r    <= 2'b00;
            rdata_r    <= '0;
        end else begin
            ar_ready_r <= S_AXI_ARVALID & ~rvalid_r & ~ar_ready_r;
            if (rd_hs_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= rd_resp_s;
                rdata_r  <= rd_data_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    genvar g;
    for (g = 0; g < N_CTRL; g++) begin : g_ctrl_out
        assign ctrl_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = ctrl_r[g];
    end

    assign S_AXI_AWREADY = aw_ready_r;
    assign S_AXI_WREADY  = aw_ready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = ar_ready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_amds_axi_regbank.sv
// Scoreboard-driven bench for amds_axi_regbank in its default configuration.
module tb_amds_axi_regbank;

    localparam int DW = 32, AW = 8, NC = 4, NCH = 8, SW = 16;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic ACLK, ARESETN;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [3:0] wstrb;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
    logic [DW-1:0] S_AXI_RDATA;
    logic [NC*DW-1:0] ctrl_out;
    logic [NCH*SW-1:0] smp_data;
    logic [NCH-1:0] smp_valid;
    logic irq;

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } exp_t;
    exp_t sb_q[$];
    exp_t e;
    logic [31:0] ctrl_m [NC];
    int n_tests = 0;
    int n_fail  = 0;

    amds_axi_regbank dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(rready),
        .ctrl_out(ctrl_out), .smp_data(smp_data), .smp_valid(smp_valid), .irq(irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [NC*DW-1:0] ctrl_model();
        return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
    endfunction

    task automatic bus_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [NCH-1:0] sv, input logic [SW-1:0] sd, input int hold,
                             output logic [1:0] resp, output bit ok, output bit stable);
        int cnt;
        ok = 1'b1; stable = 1'b1;
        @(posedge ACLK); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        cnt = 0;
        while (!S_AXI_AWREADY && cnt < 50) begin @(posedge ACLK); #1; cnt++; end
        if (!S_AXI_AWREADY) ok = 1'b0;
        smp_valid = sv; smp_data = {NCH{sd}};
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0; smp_valid = '0;
        cnt = 0;
        while (!S_AXI_BVALID && cnt < 50) begin @(posedge ACLK); #1; cnt++; end
        if (!S_AXI_BVALID) ok = 1'b0;
        resp = S_AXI_BRESP;
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            if (!S_AXI_BVALID || S_AXI_BRESP !== resp) stable = 1'b0;
        end
        bready = 1'b1;
        @(posedge ACLK); #1;
        bready = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] addr, input logic [NCH-1:0] sv, input logic [SW-1:0] sd,
                            input int hold, output logic [31:0] data, output logic [1:0] resp,
                            output bit ok, output bit stable, output logic irq_at_hs);
        int cnt;
        ok = 1'b1; stable = 1'b1;
        @(posedge ACLK); #1;
        araddr = addr; arvalid = 1'b1;
        cnt = 0;
        while (!S_AXI_ARREADY && cnt < 50) begin @(posedge ACLK); #1; cnt++; end
        if (!S_AXI_ARREADY) ok = 1'b0;
        smp_valid = sv; smp_data = {NCH{sd}};
        @(posedge ACLK); #1;
        arvalid = 1'b0; smp_valid = '0;
        irq_at_hs = irq;
        cnt = 0;
        while (!S_AXI_RVALID && cnt < 50) begin @(posedge ACLK); #1; cnt++; end
        if (!S_AXI_RVALID) ok = 1'b0;
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            if (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_RRESP !== resp) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge ACLK); #1;
        rready = 1'b0;
    endtask

    task automatic pulse(input logic [NCH-1:0] sv, input logic [SW-1:0] sd);
        @(posedge ACLK); #1;
        smp_valid = sv; smp_data = {NCH{sd}};
        @(posedge ACLK); #1;
        smp_valid = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        n_tests++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_BRESP,
             S_AXI_RRESP, S_AXI_RDATA, irq, ctrl_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdata=%h ctrl=%h irq=%b, want all zero", S_AXI_RDATA, ctrl_out, irq);
        end
        sb_q.push_back('{32'h0, OKAY});
        bus_read(8'h10, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL reset_new: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_ctrl_rw();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        for (int k = 0; k < NC; k++) begin
            ctrl_m[k] = 32'h11111111 * (k + 1);
            sb_q.push_back('{32'h0, OKAY});
            bus_write(AW'(k * 4), ctrl_m[k], 4'hF, '0, '0, 0, r, ok, st);
            e = sb_q.pop_front(); n_tests++;
            if ({ok, r} !== {1'b1, e.resp}) begin
                n_fail++; $display("FAIL ctrl_bresp%0d: got %b, want %b", k, r, e.resp);
            end
        end
        for (int k = 0; k < NC; k++) begin
            sb_q.push_back('{ctrl_m[k], OKAY});
            bus_read(AW'(k * 4), '0, '0, 0, d, r, ok, st, ih);
            e = sb_q.pop_front(); n_tests++;
            if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
                n_fail++; $display("FAIL ctrl_read%0d: got %h/%b, want %h/%b", k, d, r, e.data, e.resp);
            end
        end
        n_tests++;
        if (ctrl_out !== ctrl_model()) begin
            n_fail++; $display("FAIL ctrl_out: got %h, want %h", ctrl_out, ctrl_model());
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        int cnt; bit seen;
        @(posedge ACLK); #1;
        awaddr = 8'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        cnt = 0;
        while (!S_AXI_BVALID && cnt < 50) begin @(posedge ACLK); #1; cnt++; end
        n_tests++;
        if (S_AXI_BVALID !== 1'b1) begin
            n_fail++; $display("FAIL arst_pending: got bvalid=%b, want 1", S_AXI_BVALID);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        #2 ARESETN = 1'b0;
        #1;
        n_tests++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_BRESP,
             S_AXI_RRESP, S_AXI_RDATA, irq, ctrl_out} !== '0) begin
            n_fail++; $display("FAIL arst_outputs: got bvalid=%b ctrl=%h, want all zero", S_AXI_BVALID, ctrl_out);
        end
        for (int k = 0; k < NC; k++) ctrl_m[k] = 32'h0;
        @(posedge ACLK); @(posedge ACLK); #2 ARESETN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge ACLK); #1; if (S_AXI_BVALID) seen = 1'b1; end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL arst_no_bvalid: got bvalid seen=%b, want 0", seen);
        end
        sb_q.push_back('{32'h0, OKAY});
        bus_read(8'h08, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL arst_ctrl2: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        bus_write(8'h04, 32'hAABBCCDD, 4'b0101, '0, '0, 0, r, ok, st);
        ctrl_m[1] = 32'h00BB00DD;
        sb_q.push_back('{32'h00BB00DD, OKAY});
        bus_read(8'h04, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL wstrb_ctrl1: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_sample_irq();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        bus_write(8'h00, 32'h4, 4'hF, '0, '0, 0, r, ok, st);
        ctrl_m[0] = 32'h4;
        pulse(8'h04, 16'h1234);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b, want 0", irq); end
        @(posedge ACLK); #1;
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b, want 1", irq); end
        sb_q.push_back('{32'h4, OKAY});
        sb_q.push_back('{32'h1234, OKAY});
        sb_q.push_back('{32'h0, OKAY});
        bus_read(8'h10, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL new_set: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        bus_read(8'h20, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d, ih, irq} !== {1'b1, e.resp, e.data, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sample2: got %h/%b irq_hs=%b irq=%b, want %h/%b 1 0", d, r, ih, irq, e.data, e.resp);
        end
        bus_read(8'h10, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL new_cleared: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_ovr();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        pulse(8'h20, 16'h0505);
        pulse(8'h20, 16'h5555);
        sb_q.push_back('{32'h20, OKAY});
        sb_q.push_back('{32'h5555, OKAY});
        sb_q.push_back('{32'h0, OKAY});
        sb_q.push_back('{32'h20, OKAY});
        sb_q.push_back('{32'h7777, OKAY});
        bus_read(8'h14, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL ovr_set: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        bus_read(8'h2C, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL sample5_second: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        bus_write(8'h14, 32'h20, 4'hF, '0, '0, 0, r, ok, st);
        bus_read(8'h14, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL ovr_w1c: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        pulse(8'h20, 16'h6666);
        pulse(8'h20, 16'h6767);
        bus_write(8'h14, 32'h20, 4'hF, 8'h20, 16'h7777, 0, r, ok, st);
        bus_read(8'h14, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL ovr_set_wins: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        bus_read(8'h2C, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL sample5_third: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_simul_read();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        pulse(8'h08, 16'h0333);
        sb_q.push_back('{32'h0333, OKAY});
        sb_q.push_back('{32'h08, OKAY});
        sb_q.push_back('{32'h3AAA, OKAY});
        bus_read(8'h24, 8'h08, 16'h3AAA, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL simul_old_value: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        bus_read(8'h10, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL simul_new_kept: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        bus_read(8'h24, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL simul_new_value: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_unmapped_hold();
        logic [31:0] d; logic [1:0] r; bit ok, st; logic ih;
        sb_q.push_back('{32'h0, SLVERR});
        bus_read(8'h38, '0, '0, 10, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, st, r, d} !== {1'b1, 1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL unmapped_read: got %h/%b stable=%b, want %h/%b stable=1", d, r, st, e.data, e.resp);
        end
        sb_q.push_back('{32'h0, SLVERR});
        bus_write(8'h38, 32'hFFFFFFFF, 4'hF, '0, '0, 10, r, ok, st);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, st, r} !== {1'b1, 1'b1, e.resp}) begin
            n_fail++; $display("FAIL unmapped_write: got %b stable=%b, want %b stable=1", r, st, e.resp);
        end
        sb_q.push_back('{32'h0, OKAY});
        bus_write(8'h10, 32'hFFFFFFFF, 4'hF, '0, '0, 0, r, ok, st);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r} !== {1'b1, e.resp}) begin
            n_fail++; $display("FAIL ro_write_resp: got %b, want %b", r, e.resp);
        end
        sb_q.push_back('{32'h0, OKAY});
        bus_read(8'h10, '0, '0, 0, d, r, ok, st, ih);
        e = sb_q.pop_front(); n_tests++;
        if ({ok, r, d} !== {1'b1, e.resp, e.data}) begin
            n_fail++; $display("FAIL ro_write_noeffect: got %h/%b, want %h/%b", d, r, e.data, e.resp);
        end
        n_tests++;
        if (ctrl_out !== ctrl_model()) begin
            n_fail++; $display("FAIL unmapped_ctrl: got %h, want %h", ctrl_out, ctrl_model());
        end
    endtask

    initial begin
        ARESETN = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0; arvalid = 1'b0; rready = 1'b0; smp_data = '0; smp_valid = '0;
        for (int k = 0; k < NC; k++) ctrl_m[k] = 32'h0;
        #22 ARESETN = 1'b1;
        test_reset();
        test_ctrl_rw();
        test_async_reset();
        test_wstrb();
        test_sample_irq();
        test_ovr();
        test_simul_read();
        test_unmapped_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
